// File: rtl/axi_decerr_r_responder.sv
// Read-side DECERR responder for unmapped AR requests. It waits for routed reads to drain,
// then returns arlen+1 DECERR beats on R and pulses error_gnt_o on the final handshake.
module axi_decerr_r_responder #(
   parameter int unsigned ID_WIDTH        = 4,
   parameter int unsigned DATA_WIDTH      = 64,
   parameter int unsigned USER_WIDTH      = 6,
   parameter int unsigned MAX_OUTSTANDING = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  incr_req_i,
   input  logic                  decr_req_i,
   output logic                  full_counter_o,
   output logic                  outstanding_trans_o,
   input  logic                  sample_ardata_info_i,
   input  logic [ID_WIDTH-1:0]   arid_i,
   input  logic [7:0]            arlen_i,
   input  logic [USER_WIDTH-1:0] aruser_i,
   output logic                  error_gnt_o,
   output logic                  rvalid_o,
   input  logic                  rready_i,
   output logic [ID_WIDTH-1:0]   rid_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic [1:0]            rresp_o,
   output logic                  rlast_o,
   output logic [USER_WIDTH-1:0] ruser_o
);

   localparam int unsigned      CNT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {StIdle, StDrain, StSend} state_e;

   state_e                state_q;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [7:0]            beat_q;
   logic [7:0]            len_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [USER_WIDTH-1:0] user_q;
   logic                  send;

   // Saturating outstanding counter; simultaneous incr and decr cancel out.
   always_comb begin
      cnt_d = cnt_q;
      if (incr_req_i && !decr_req_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end else if (decr_req_i && !incr_req_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign full_counter_o      = (cnt_q == CNT_MAX);
   assign outstanding_trans_o = (cnt_q != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         beat_q  <= '0;
         len_q   <= '0;
         id_q    <= '0;
         user_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (sample_ardata_info_i) begin
                  id_q    <= arid_i;
                  len_q   <= arlen_i;
                  user_q  <= aruser_i;
                  beat_q  <= '0;
                  state_q <= StDrain;
               end
            end
            // Routed reads must complete before the error response may use the R channel.
            StDrain: begin
               if (cnt_q == '0) begin
                  state_q <= StSend;
               end
            end
            StSend: begin
               if (rready_i) begin
                  if (rlast_o) begin
                     state_q <= StIdle;
                  end else begin
                     beat_q <= beat_q + 8'd1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign send        = (state_q == StSend);
   assign rvalid_o    = send;
   assign rlast_o     = send && (beat_q == len_q);
   assign rresp_o     = send ? 2'b11 : 2'b00;
   assign rdata_o     = '0;
   assign rid_o       = send ? id_q : '0;
   assign ruser_o     = send ? user_q : '0;
   assign error_gnt_o = send && rready_i && rlast_o;

endmodule

// File: tb/tb_axi_decerr_r_responder.sv
// Bench for axi_decerr_r_responder: directed scenarios plus random traffic, all checked
// against a queue-based model of the expected R beats and the outstanding count.
module tb_axi_decerr_r_responder;

   localparam int IDW  = 4;
   localparam int DW   = 64;
   localparam int UW   = 6;
   localparam int MAXO = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           incr_req_i = 1'b0;
   logic           decr_req_i = 1'b0;
   logic           full_counter_o;
   logic           outstanding_trans_o;
   logic           sample_ardata_info_i = 1'b0;
   logic [IDW-1:0] arid_i = '0;
   logic [7:0]     arlen_i = '0;
   logic [UW-1:0]  aruser_i = '0;
   logic           error_gnt_o;
   logic           rvalid_o;
   logic           rready_i = 1'b0;
   logic [IDW-1:0] rid_o;
   logic [DW-1:0]  rdata_o;
   logic [1:0]     rresp_o;
   logic           rlast_o;
   logic [UW-1:0]  ruser_o;

   axi_decerr_r_responder #(
      .ID_WIDTH(IDW), .DATA_WIDTH(DW), .USER_WIDTH(UW), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .incr_req_i(incr_req_i), .decr_req_i(decr_req_i),
      .full_counter_o(full_counter_o), .outstanding_trans_o(outstanding_trans_o),
      .sample_ardata_info_i(sample_ardata_info_i), .arid_i(arid_i), .arlen_i(arlen_i),
      .aruser_i(aruser_i), .error_gnt_o(error_gnt_o), .rvalid_o(rvalid_o),
      .rready_i(rready_i), .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o),
      .rlast_o(rlast_o), .ruser_o(ruser_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IDW-1:0] id;
      logic [UW-1:0]  user;
      bit             last;
   } beat_t;

   beat_t exp_q[$];
   int    m_cnt;
   bit    m_pending;  // an error response is owed
   bit    m_open;     // R channel released to the error response
   int    n_tests = 0;
   int    n_fail = 0;
   int    beats_seen = 0;
   int    gnts_seen = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt     = 0;
      m_pending = 0;
      m_open    = 0;
      exp_q.delete();
   endtask

   task automatic check_outputs();
      bit v;
      v = m_open && (exp_q.size() > 0);
      check_eq("full", 64'(full_counter_o), 64'(m_cnt == MAXO));
      check_eq("outstanding", 64'(outstanding_trans_o), 64'(m_cnt != 0));
      check_eq("rvalid", 64'(rvalid_o), 64'(v));
      check_eq("rdata", rdata_o, 64'd0);
      if (v) begin
         check_eq("rid", 64'(rid_o), 64'(exp_q[0].id));
         check_eq("ruser", 64'(ruser_o), 64'(exp_q[0].user));
         check_eq("rlast", 64'(rlast_o), 64'(exp_q[0].last));
         check_eq("rresp", 64'(rresp_o), 64'd3);
         check_eq("gnt", 64'(error_gnt_o), 64'(rready_i && exp_q[0].last));
      end else begin
         check_eq("rlast_idle", 64'(rlast_o), 64'd0);
         check_eq("rresp_idle", 64'(rresp_o), 64'd0);
         check_eq("gnt_idle", 64'(error_gnt_o), 64'd0);
      end
   endtask

   // Advance the model across one rising edge using the inputs currently driven.
   task automatic model_update();
      bit p0, open_next, l;
      p0        = m_pending;
      open_next = m_open;
      if (m_pending && !m_open && m_cnt == 0) open_next = 1;
      if (m_open && rready_i && exp_q.size() > 0) begin
         l = exp_q[0].last;
         void'(exp_q.pop_front());
         if (l) begin
            m_pending = 0;
            open_next = 0;
         end
      end
      m_open = open_next;
      if (incr_req_i && !decr_req_i && m_cnt < MAXO) m_cnt++;
      else if (decr_req_i && !incr_req_i && m_cnt > 0) m_cnt--;
      if (!p0 && sample_ardata_info_i) begin
         m_pending = 1;
         for (int i = 0; i <= int'(arlen_i); i++) begin
            exp_q.push_back('{id: arid_i, user: aruser_i, last: (i == int'(arlen_i))});
         end
      end
   endtask

   task automatic step(input bit inc, input bit dec, input bit smp, input logic [IDW-1:0] id,
                       input logic [7:0] len, input logic [UW-1:0] usr, input bit rdy);
      @(negedge clk);
      incr_req_i = inc;
      decr_req_i = dec;
      sample_ardata_info_i = smp;
      arid_i = id;
      arlen_i = len;
      aruser_i = usr;
      rready_i = rdy;
      #1;
      check_outputs();
      if (rvalid_o && rready_i) beats_seen++;
      if (error_gnt_o) gnts_seen++;
      model_update();
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, '0, rdy);
   endtask

   int b0, g0;

   initial begin
      model_reset();
      #3;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      // Counter saturation and cancellation
      for (int i = 0; i < 8; i++) step(1, 0, 0, '0, '0, '0, 0);
      idle(1, 0);
      check_eq("full_after8", 64'(full_counter_o), 64'd1);
      step(1, 0, 0, '0, '0, '0, 0);
      step(1, 1, 0, '0, '0, '0, 0);
      idle(1, 0);
      check_eq("full_sat", 64'(full_counter_o), 64'd1);
      for (int i = 0; i < 9; i++) step(0, 1, 0, '0, '0, '0, 0);
      idle(1, 0);
      check_eq("empty_sat", 64'(outstanding_trans_o), 64'd0);

      // Drain behind three routed reads
      for (int i = 0; i < 3; i++) step(1, 0, 0, '0, '0, '0, 1);
      b0 = beats_seen; g0 = gnts_seen;
      step(0, 0, 1, 4'd5, 8'd0, 6'd0, 1);
      idle(4, 1);
      check_eq("drain_hold", 64'(beats_seen - b0), 64'd0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, '0, '0, '0, 1);
      idle(4, 1);
      check_eq("drain_beats", 64'(beats_seen - b0), 64'd1);
      check_eq("drain_gnt", 64'(gnts_seen - g0), 64'd1);

      // Burst with toggling backpressure
      b0 = beats_seen; g0 = gnts_seen;
      step(0, 0, 1, 4'd9, 8'd3, 6'h2A, 0);
      for (int i = 0; i < 14; i++) step(0, 0, 0, '0, '0, '0, i[0] == 1'b0);
      check_eq("burst_beats", 64'(beats_seen - b0), 64'd4);
      check_eq("burst_gnt", 64'(gnts_seen - g0), 64'd1);

      // Maximum-length burst
      b0 = beats_seen; g0 = gnts_seen;
      step(0, 0, 1, 4'd3, 8'd255, 6'h11, 1);
      idle(262, 1);
      check_eq("max_beats", 64'(beats_seen - b0), 64'd256);
      check_eq("max_gnt", 64'(gnts_seen - g0), 64'd1);

      // Second sample while sending is ignored
      b0 = beats_seen;
      step(0, 0, 1, 4'd1, 8'd3, 6'h05, 0);
      idle(3, 0);
      step(0, 0, 1, 4'd7, 8'd0, 6'h3F, 1);
      idle(8, 1);
      check_eq("ignore_beats", 64'(beats_seen - b0), 64'd4);

      // Reset during the second beat of a burst
      step(0, 0, 1, 4'd6, 8'd3, 6'h01, 1);
      step(1, 0, 0, '0, '0, '0, 1);
      step(1, 0, 0, '0, '0, '0, 1);
      @(negedge clk);
      incr_req_i = 0;
      sample_ardata_info_i = 0;
      rst_n = 1'b0;
      #1;
      check_eq("rst_rvalid", 64'(rvalid_o), 64'd0);
      check_eq("rst_outstanding", 64'(outstanding_trans_o), 64'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      b0 = beats_seen;
      idle(6, 1);
      check_eq("rst_no_beats", 64'(beats_seen - b0), 64'd0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
              IDW'($urandom), (($urandom % 16) == 0) ? 8'($urandom) : 8'($urandom % 4),
              UW'($urandom), ($urandom % 3) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
